sprite_renderer_param: RTL

SPRITE_RENDERER_PARAM -- requirements
Module: sprite_renderer_param

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_renderer_param.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite blocks: state encoding and sizing constants.
package sprite_pkg;

    // Row controller states; any value outside this set is recovered to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_LOAD   = 3'd1,
        ST_FETCH_SETUP = 3'd2,
        ST_FETCH_WAIT  = 3'd3,
        ST_WAIT_HSTART = 3'd4,
        ST_DRAW        = 3'd5
    } sprite_state_e;

    // Mirror doubles the row and xscale doubles each pixel, so a row is at most 4x WIDTH cycles.
    localparam int SPRITE_MAX_STRETCH = 4;

endpackage

// File: rtl/sprite_renderer_param.sv
// Sprite row renderer: fetches one bitmap row per line from an external ROM and
// shifts it out on gfx, with optional horizontal mirror, vertical flip and 2x stretch.
//
// state          | meaning
// ---------------+------------------------------------------------------------
// ST_IDLE        | no sprite; waits for vstart, latches mode bits
// ST_WAIT_LOAD   | between rows; waits for load before touching the ROM
// ST_FETCH_SETUP | drives rom_addr for the current row
// ST_FETCH_WAIT  | counts down ROM latency, then captures rom_bits
// ST_WAIT_HSTART | row captured; waits for hstart
// ST_DRAW        | emits one pixel per cycle for the whole (stretched) row
module sprite_renderer_param
    import sprite_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int HEIGHT  = 16,
    parameter  int ROM_LAT = 1,
    localparam int AW      = $clog2(HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vstart,
    input  logic             load,
    input  logic             hstart,
    input  logic             mirror,
    input  logic             flip_y,
    input  logic             xscale,
    output logic [AW-1:0]    rom_addr,
    input  logic [WIDTH-1:0] rom_bits,
    output logic             gfx,
    output logic             in_progress,
    output logic             done
);

    localparam int            XW       = $clog2(SPRITE_MAX_STRETCH * WIDTH);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [AW-1:0] Y_LAST   = AW'(HEIGHT - 1);
    localparam logic [1:0]    LAT_INIT = 2'(ROM_LAT - 1);

    sprite_state_e    state_q;
    logic [AW-1:0]    ycount_q;
    logic [XW-1:0]    xcount_q;
    logic [1:0]       lat_q;
    logic [AW-1:0]    rom_addr_q;
    logic [WIDTH-1:0] row_q;
    logic             gfx_q;
    logic             done_q;
    logic             busy_q;
    logic             mirror_q;
    logic             flip_q;
    logic             xscale_q;

    logic [XW-1:0]    pidx_d;
    logic [CW-1:0]    ridx_d;
    logic             pix_d;
    logic [XW-1:0]    len_m1_d;
    logic [AW-1:0]    fetch_addr_d;

    // Pixel select, row length and fetch address derived from the latched modes.
    always_comb begin
        pidx_d = xscale_q ? (xcount_q >> 1) : xcount_q;
        if (pidx_d < XW'(WIDTH)) begin
            ridx_d = CW'(pidx_d);
        end else begin
            ridx_d = CW'(XW'(2 * WIDTH - 1) - pidx_d);
        end
        pix_d = row_q[ridx_d];
        case ({mirror_q, xscale_q})
            2'b00:   len_m1_d = XW'(WIDTH - 1);
            2'b11:   len_m1_d = XW'(4 * WIDTH - 1);
            default: len_m1_d = XW'(2 * WIDTH - 1);
        endcase
        fetch_addr_d = flip_q ? (Y_LAST - ycount_q) : ycount_q;
    end

    // Row sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ycount_q   <= '0;
            xcount_q   <= '0;
            lat_q      <= '0;
            rom_addr_q <= '0;
            row_q      <= '0;
            gfx_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            mirror_q   <= 1'b0;
            flip_q     <= 1'b0;
            xscale_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ycount_q <= '0;
                    gfx_q    <= 1'b0;
                    if (vstart) begin
                        mirror_q <= mirror;
                        flip_q   <= flip_y;
                        xscale_q <= xscale;
                        busy_q   <= 1'b1;
                        state_q  <= ST_WAIT_LOAD;
                    end
                end
                ST_WAIT_LOAD: begin
                    xcount_q <= '0;
                    gfx_q    <= 1'b0;
                    if (load) begin
                        state_q <= ST_FETCH_SETUP;
                    end
                end
                ST_FETCH_SETUP: begin
                    rom_addr_q <= fetch_addr_d;
                    lat_q      <= LAT_INIT;
                    state_q    <= ST_FETCH_WAIT;
                end
                ST_FETCH_WAIT: begin
                    if (lat_q == 2'd0) begin
                        row_q   <= rom_bits;
                        state_q <= ST_WAIT_HSTART;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                ST_WAIT_HSTART: begin
                    gfx_q <= 1'b0;
                    if (hstart) begin
                        state_q <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    gfx_q <= pix_d;
                    if (xcount_q == len_m1_d) begin
                        if (ycount_q == Y_LAST) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            ycount_q <= ycount_q + 1'b1;
                            state_q  <= ST_WAIT_LOAD;
                        end
                    end else begin
                        xcount_q <= xcount_q + 1'b1;
                    end
                end
                default: begin
                    gfx_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr    = rom_addr_q;
    assign gfx         = gfx_q;
    assign done        = done_q;
    assign in_progress = busy_q;

endmodule
